lcd_frame_ctrl: RTL and testbench
=================================

# lcd_frame_ctrl

Sequencer for the 16x2 HD44780-style character LCD on the pet feeder board. Runs the one-time LCD power-up/init command sequence, then redraws the full 32-character screen. For each character it presents a 5-bit index to the combinational string ROM, registers the returned ASCII byte, and drives the LCD write strobes with programmable setup/enable/hold timing. It sits between the feeder FSM (source of the one-hot state code) and the LCD pins.

## Interface
- `SETUP_CYC`, default 2: cycles RS/DATA are stable before EN rises; must be ≥1.
- `EN_CYC`, default 12: EN high width in cycles; must be ≥1.
- `HOLD_CYC`, default 2500: EN-low wait after each write (50 µs at 50 MHz); must be ≥1.
- `CLR_CYC`, default 100000: EN-low wait after the clear command (0x01); replaces `HOLD_CYC` for that write.
- `POWERUP_CYC`, default 1000000: idle wait after reset before the first command.

- `iCLK` in 1: system clock; all logic on the rising edge.
- `iRST_N` in 1: asynchronous, active-low reset.
- `iSTATE_CODE` in 5: one-hot feeder state; selects the screen text.
- `iCHAR` in 8: ASCII byte from the string ROM for the current `oINDEX`/`oSTATE_CODE`.
- `oINDEX` out 5: ROM index; bit 4 is the line, bits 3:0 the column.
- `oSTATE_CODE` out 5: state code latched for the current frame; drives the ROM.
- `LCD_DATA` out 8: LCD data bus.
- `LCD_RS` out 1: 0 = command, 1 = character.
- `LCD_RW` out 1: always 0 (write only).
- `LCD_EN` out 1: LCD enable strobe.
- `LCD_ON` out 1: LCD power enable.
- `oBUSY` out 1: high from reset until the first frame completes, and during every frame.
- `oFRAME_DONE` out 1: one-cycle pulse when the last write of a frame ends its hold.

## Operation
- Reset values:
  - `oINDEX` = 0, `oSTATE_CODE` = 0, `LCD_DATA` = 0x00, `LCD_RS` = 0, `LCD_RW` = 0, `LCD_EN` = 0, `oFRAME_DONE` = 0.
  - `LCD_ON` = 0, `oBUSY` = 1.
  - FSM in PWRUP with the delay counter cleared.
- `LCD_ON` goes to 1 on the first clock after reset deasserts and stays at 1.

States:
- **PWRUP**: count `POWERUP_CYC` cycles, then go to INIT.
- **INIT**: issue five commands in order: 0x38, 0x0C, 0x01, 0x06, 0x80.
- **FRAME**: write sequence is:
  - command 0x80;
  - characters at index 0x00–0x0F;
  - command 0xC0;
  - characters at index 0x10–0x1F.
  - That is 34 writes per frame.
- **IDLE**: wait for a redraw condition (see Configuration).

Every write (command or character) runs LOAD → SETUP → PULSE → HOLD:
- **LOAD** (1 cycle):
  - Character writes: `oINDEX` updated.
  - Command writes: `oINDEX` unchanged.
- **SETUP** (`SETUP_CYC` cycles):
  - On entry, `LCD_DATA` takes `iCHAR` (character write) or the command constant.
  - On entry, `LCD_RS` is set to match the write type.
  - `LCD_EN` = 0.
- **PULSE** (`EN_CYC` cycles): `LCD_EN` = 1; `LCD_DATA` and `LCD_RS` held.
- **HOLD**: `LCD_EN` = 0 for `HOLD_CYC` cycles, or `CLR_CYC` for command 0x01; `LCD_DATA` and `LCD_RS` held.

Frame behaviour:
- `oSTATE_CODE` latches `iSTATE_CODE` in the LOAD cycle of the frame's first write (command 0x80) and is constant for the whole frame.
- A mid-frame change of `iSTATE_CODE` does not tear the screen.
- `oBUSY` falls the cycle after `oFRAME_DONE` when the FSM enters IDLE. It rises on the clock that leaves IDLE.
- Reset mid-write: `LCD_EN` drops to 0 asynchronously, and the full PWRUP + INIT sequence reruns.

## Timing
- One write takes 1 + `SETUP_CYC` + `EN_CYC` + `HOLD_CYC` cycles; the clear command uses `CLR_CYC` in place of `HOLD_CYC`.
- The first frame starts the cycle after the last INIT hold ends.
- `iCHAR` is sampled exactly one cycle after `oINDEX` changes. The ROM must be combinational (zero latency).
- In IDLE, a redraw condition seen on cycle N puts the FSM in LOAD of command 0x80 on cycle N+1.
- `oFRAME_DONE` is asserted in the final HOLD cycle of write 34.

## Configuration
- `LCD_AUTO_REFRESH_EN`:
  - **Defined**: IDLE lasts exactly one cycle and a new frame always follows, so the display is redrawn continuously and `oBUSY` drops for one cycle per frame.
  - **Undefined**: IDLE holds until `iSTATE_CODE` ≠ `oSTATE_CODE`. A change during a frame causes a new frame immediately after `oFRAME_DONE`. With no change, the bus stays quiet indefinitely.

## Test plan
Parameters for all scenarios: `SETUP_CYC`=2, `EN_CYC`=4, `HOLD_CYC`=8, `CLR_CYC`=20, `POWERUP_CYC`=16; behavioural ROM model attached.

- **Reset and init**:
  - Stimulus: release reset with `iSTATE_CODE`=5'b00000.
  - Required: all outputs at their reset values during reset; `LCD_EN` stays low for 16 cycles.
  - Required: five EN pulses, each 4 cycles wide, carrying 0x38, 0x0C, 0x01, 0x06, 0x80 with `LCD_RS`=0.
  - Required: 20-cycle hold after 0x01, 8-cycle hold after the others.
- **First frame**:
  - Required: 34 writes, with `LCD_RS` pattern 0, then sixteen 1s, then 0, then sixteen 1s.
  - Required: characters decoded in order read "Start" followed by 11 spaces on line 1, then "Press Ok" followed by 8 spaces on line 2.
  - Required: `oFRAME_DONE` pulses exactly once.
- **Change during a frame** (macro undefined):
  - Stimulus: switch `iSTATE_CODE` to 5'b10000 during character 5.
  - Required: the frame completes unchanged ("Start" text).
  - Required: a new frame begins one cycle after IDLE is entered and shows "Done".
- **Quiet when unchanged** (macro undefined):
  - Stimulus: hold `iSTATE_CODE` constant.
  - Required: no `LCD_EN` activity for 2000 cycles after `oFRAME_DONE`; `oBUSY` = 0.
- **Continuous refresh** (macro defined):
  - Stimulus: hold `iSTATE_CODE` constant.
  - Required: back-to-back frames separated by exactly one IDLE cycle.
- **Reset mid-PULSE**:
  - Stimulus: assert `iRST_N` low while `LCD_EN`=1 in a frame.
  - Required: `LCD_EN` falls in the same cycle; `oBUSY` = 1; PWRUP + INIT rerun after release.

Source files
------------

// File: rtl/lcd_frame_ctrl_if.sv
// LCD pin bundle between lcd_frame_ctrl (master) and the character LCD (slave).
interface lcd_frame_ctrl_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_ON;

    modport master (output LCD_DATA, output LCD_RS, output LCD_RW, output LCD_EN, output LCD_ON);
    modport slave  (input  LCD_DATA, input  LCD_RS, input  LCD_RW, input  LCD_EN, input  LCD_ON);
endinterface

// File: rtl/lcd_frame_ctrl.sv
// 16x2 HD44780 frame sequencer: power-up wait, init commands, then full-screen
// redraws fed from a combinational string ROM.
// Optional feature macro: LCD_AUTO_REFRESH_EN (continuous redraw when defined,
// redraw only on a state-code change when undefined).
module lcd_frame_ctrl #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned EN_CYC      = 12,
    parameter int unsigned HOLD_CYC    = 2500,
    parameter int unsigned CLR_CYC     = 100000,
    parameter int unsigned POWERUP_CYC = 1000000
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [4:0]        iSTATE_CODE,
    input  logic [7:0]        iCHAR,
    output logic [4:0]        oINDEX,
    output logic [4:0]        oSTATE_CODE,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    lcd_frame_ctrl_if.master  lcd
);

    localparam int unsigned MAX_AB  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned MAX_CD  = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
    localparam int unsigned MAX_AD  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MAX_ALL = (MAX_AD > POWERUP_CYC) ? MAX_AD : POWERUP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);
    localparam int unsigned WR_W    = 6;
    localparam int unsigned LAST_INIT_WR  = 4;
    localparam int unsigned LAST_FRAME_WR = 33;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frame_q, frame_d;
    logic [WR_W-1:0]   wr_q, wr_d;
    logic [4:0]        index_q, index_d;
    logic [4:0]        code_q, code_d;
    logic [7:0]        data_q, data_d;
    logic              rs_q, rs_d;
    logic              en_q, en_d;
    logic              on_q, on_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  hold_last;
    logic              redraw;

    // Frame writes 0 and 17 are the line-address commands; the rest are characters.
    function automatic logic wr_is_char(input logic frame, input logic [WR_W-1:0] wr);
        return frame && (wr != WR_W'(0)) && (wr != WR_W'(17));
    endfunction

    // Command byte for a non-character write.
    function automatic logic [7:0] wr_cmd(input logic frame, input logic [WR_W-1:0] wr);
        logic [7:0] c;
        if (frame) begin
            c = (wr == WR_W'(0)) ? 8'h80 : 8'hC0;
        end else begin
            case (wr)
                WR_W'(0): c = 8'h38;
                WR_W'(1): c = 8'h0C;
                WR_W'(2): c = 8'h01;
                WR_W'(3): c = 8'h06;
                default:  c = 8'h80;
            endcase
        end
        return c;
    endfunction

    // ROM index of a character write, skipping the two command slots.
    function automatic logic [4:0] wr_char_idx(input logic [WR_W-1:0] wr);
        return (wr < WR_W'(17)) ? 5'(wr - WR_W'(1)) : 5'(wr - WR_W'(2));
    endfunction

    // Next-state and next-output logic for the write sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        wr_d    = wr_q;
        index_d = index_q;
        code_d  = code_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        on_d    = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        redraw  = 1'b0;

        // The clear command needs the long settle time.
        hold_last = (!rs_q && (data_q == 8'h01)) ? CNT_W'(CLR_CYC - 1) : CNT_W'(HOLD_CYC - 1);

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == CNT_W'(POWERUP_CYC - 1)) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    frame_d = 1'b0;
                    wr_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD: begin
                state_d = S_SETUP;
                cnt_d   = '0;
                en_d    = 1'b0;
                rs_d    = wr_is_char(frame_q, wr_q);
                data_d  = wr_is_char(frame_q, wr_q) ? iCHAR : wr_cmd(frame_q, wr_q);
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = S_PULSE;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == CNT_W'(EN_CYC - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == hold_last) begin
                    cnt_d = '0;
                    if (!frame_q && (wr_q == WR_W'(LAST_INIT_WR))) begin
                        state_d = S_LOAD;
                        frame_d = 1'b1;
                        wr_d    = '0;
                    end else if (frame_q && (wr_q == WR_W'(LAST_FRAME_WR))) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                        wr_d    = wr_q + WR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
`ifdef LCD_AUTO_REFRESH_EN
                redraw = 1'b1;
`else
                redraw = (iSTATE_CODE != code_q);
`endif
                if (redraw) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    frame_d = 1'b1;
                    wr_d    = '0;
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
            end
        endcase

        // Entering LOAD: present the ROM index and, on a frame's first write, freeze the text.
        if (state_d == S_LOAD) begin
            if (wr_is_char(frame_d, wr_d)) begin
                index_d = wr_char_idx(wr_d);
            end
            if (frame_d && (wr_d == '0)) begin
                code_d = iSTATE_CODE;
            end
        end

        done_d = frame_q && (wr_q == WR_W'(LAST_FRAME_WR)) && (state_d == S_HOLD) && (cnt_d == hold_last);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            frame_q <= 1'b0;
            wr_q    <= '0;
            index_q <= '0;
            code_q  <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            on_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            wr_q    <= wr_d;
            index_q <= index_d;
            code_q  <= code_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            on_q    <= on_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oINDEX       = index_q;
    assign oSTATE_CODE  = code_q;
    assign oBUSY        = busy_q;
    assign oFRAME_DONE  = done_q;
    assign lcd.LCD_DATA = data_q;
    assign lcd.LCD_RS   = rs_q;
    assign lcd.LCD_RW   = 1'b0;
    assign lcd.LCD_EN   = en_q;
    assign lcd.LCD_ON   = on_q;

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Self-checking bench for lcd_frame_ctrl with a behavioural string ROM and a
// write scoreboard. Build with LCD_AUTO_REFRESH_EN to cover continuous refresh.
module tb_lcd_frame_ctrl;

    localparam int unsigned SETUP_CYC   = 2;
    localparam int unsigned EN_CYC      = 4;
    localparam int unsigned HOLD_CYC    = 8;
    localparam int unsigned CLR_CYC     = 20;
    localparam int unsigned POWERUP_CYC = 16;
    localparam int GAP_STD   = HOLD_CYC + 1 + SETUP_CYC;
    localparam int GAP_CLR   = CLR_CYC + 1 + SETUP_CYC;
    localparam int GAP_PWRUP = POWERUP_CYC + 1 + SETUP_CYC;
    localparam int GAP_IDLE1 = GAP_STD + 1;

    logic       clk;
    logic       rst_n;
    logic [4:0] state_code;
    logic [7:0] rom_char;
    logic [4:0] index_o;
    logic [4:0] code_o;
    logic       busy_o;
    logic       done_o;

    lcd_frame_ctrl_if lcd ();

    lcd_frame_ctrl #(
        .SETUP_CYC   (SETUP_CYC),
        .EN_CYC      (EN_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .CLR_CYC     (CLR_CYC),
        .POWERUP_CYC (POWERUP_CYC)
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iSTATE_CODE (state_code),
        .iCHAR       (rom_char),
        .oINDEX      (index_o),
        .oSTATE_CODE (code_o),
        .oBUSY       (busy_o),
        .oFRAME_DONE (done_o),
        .lcd         (lcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural string ROM: 5'b10000 shows "Done", anything else the start screen.
    function automatic logic [7:0] rom(input logic [4:0] code, input logic [4:0] idx);
        string s;
        int    col;
        col = int'(idx[3:0]);
        if (code == 5'b10000) begin
            if (idx[4]) s = "";
            else        s = "Done";
        end else begin
            if (idx[4]) s = "Press Ok";
            else        s = "Start";
        end
        if (col < s.len()) return s[col];
        return 8'h20;
    endfunction

    always_comb rom_char = rom(code_o, index_o);

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] code;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   fd_count    = 0;
    int   rise_count  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_init();
        exp_q.push_back('{1'b0, 8'h38, 5'd0, GAP_PWRUP});
        exp_q.push_back('{1'b0, 8'h0C, 5'd0, GAP_STD});
        exp_q.push_back('{1'b0, 8'h01, 5'd0, GAP_STD});
        exp_q.push_back('{1'b0, 8'h06, 5'd0, GAP_CLR});
        exp_q.push_back('{1'b0, 8'h80, 5'd0, GAP_STD});
    endtask

    // gap 0 means the idle time before the frame is unbounded and not checked.
    task automatic push_frame(input logic [4:0] code, input int first_gap);
        exp_q.push_back('{1'b0, 8'h80, code, first_gap});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, rom(code, 5'(i)), code, GAP_STD});
        exp_q.push_back('{1'b0, 8'hC0, code, GAP_STD});
        for (int i = 16; i < 32; i++) exp_q.push_back('{1'b1, rom(code, 5'(i)), code, GAP_STD});
    endtask

    task automatic wait_fd(input int target);
        int n = 0;
        while ((fd_count < target) && (n < 3000)) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("frame_done_wait", 32'(fd_count >= target), 32'd1);
    endtask

    task automatic wait_en_idx(input logic [4:0] idx);
        int n = 0;
        @(negedge clk);
        while (!(lcd.LCD_EN && (index_o == idx)) && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        chk("en_idx_wait", 32'(lcd.LCD_EN && (index_o == idx)), 32'd1);
    endtask

    // Write monitor: pops the scoreboard on every EN rise, checks widths and gaps.
    initial begin
        logic prev_en, prev_fd, busy_chk;
        int   low_cnt, high_cnt;
        exp_t e;
        prev_en = 1'b0; prev_fd = 1'b0; busy_chk = 1'b0; low_cnt = 0; high_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0; prev_fd = 1'b0; busy_chk = 1'b0; low_cnt = 0; high_cnt = 0;
            end else begin
                if (busy_chk) begin
                    chk("busy_after_done", 32'(busy_o), 32'd0);
                    busy_chk = 1'b0;
                end
                if (done_o) begin
                    fd_count++;
                    chk("done_single", 32'(prev_fd), 32'd0);
                    chk("done_en_low", 32'(lcd.LCD_EN), 32'd0);
                    busy_chk = 1'b1;
                end
                if (lcd.LCD_EN) begin
                    if (!prev_en) begin
                        rise_count++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_write", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rs", 32'(lcd.LCD_RS), 32'(e.rs));
                            chk("data", 32'(lcd.LCD_DATA), 32'(e.data));
                            chk("state_code", 32'(code_o), 32'(e.code));
                            chk("rw", 32'(lcd.LCD_RW), 32'd0);
                            if (e.gap != 0) chk("en_low_gap", 32'(low_cnt), 32'(e.gap));
                        end
                        high_cnt = 0;
                    end
                    high_cnt++;
                end else begin
                    if (prev_en) begin
                        chk("en_width", 32'(high_cnt), 32'(EN_CYC));
                        low_cnt = 0;
                    end
                    low_cnt++;
                end
                prev_en = lcd.LCD_EN;
                prev_fd = done_o;
            end
        end
    end

    // Directed sequence.
    initial begin
        int rc;
        int fd_base;
        rst_n      = 1'b0;
        state_code = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_index", 32'(index_o), 32'd0);
        chk("rst_code", 32'(code_o), 32'd0);
        chk("rst_data", 32'(lcd.LCD_DATA), 32'd0);
        chk("rst_rs", 32'(lcd.LCD_RS), 32'd0);
        chk("rst_rw", 32'(lcd.LCD_RW), 32'd0);
        chk("rst_en", 32'(lcd.LCD_EN), 32'd0);
        chk("rst_on", 32'(lcd.LCD_ON), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);

        push_init();
        push_frame(5'b00000, GAP_STD);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("lcd_on", 32'(lcd.LCD_ON), 32'd1);
        chk("busy_pwrup", 32'(busy_o), 32'd1);

`ifndef LCD_AUTO_REFRESH_EN
        wait_en_idx(5'd5);
        state_code = 5'b10000;
        push_frame(5'b10000, GAP_IDLE1);
        wait_fd(1);
        chk("frame1_code", 32'(code_o), 32'd0);
        wait_fd(2);
        chk("frame2_code", 32'(code_o), 32'h10);
        chk("frame2_drained", 32'(exp_q.size()), 32'd0);

        rc = rise_count;
        repeat (2000) @(posedge clk);
        #1;
        chk("quiet_en", 32'(rise_count), 32'(rc));
        chk("quiet_busy", 32'(busy_o), 32'd0);
        chk("quiet_done", 32'(fd_count), 32'd2);

        state_code = 5'b00000;
        push_frame(5'b00000, 0);
`else
        push_frame(5'b00000, GAP_IDLE1);
        push_frame(5'b00000, GAP_IDLE1);
        push_frame(5'b00000, GAP_IDLE1);
        wait_fd(1);
        chk("frame1_count", 32'(fd_count), 32'd1);
        wait_fd(3);
        chk("refresh_count", 32'(fd_count), 32'd3);
`endif

        wait_en_idx(5'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(lcd.LCD_EN), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd1);
        chk("mid_rst_on", 32'(lcd.LCD_ON), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        push_init();
        push_frame(5'b00000, GAP_STD);
        fd_base = fd_count;
        #1 rst_n = 1'b1;
        wait_fd(fd_base + 1);
        chk("rerun_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
